wb_uart_fifo: RTL and testbench



---
 rtl/wb_uart_fifo.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_wb_uart_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_fifo.sv
// wb_uart_fifo: Wishbone-slave UART with TX/RX FIFOs, runtime baud divisor
// and sticky error flags.
//
// Optional feature macro: WB_UART_PARITY_EN
//   Defined   -> CTRL[16] parity enable, CTRL[17] odd(1)/even(0); a parity bit
//                follows the data bits on TX and is checked on RX.
//   Undefined -> CTRL[17:16] read 0, STATUS[6] is constant 0.
//
// Register map (full 32-bit address compare):
//   ADDR_TX_DATA  W: push byte (dropped when full)          R: 0
//   ADDR_RX_DATA  R: pop head byte (0 when empty)            W: ignored
//   ADDR_STATUS   R: [0] tx_empty [1] tx_full [2] rx_nonempty [3] rx_full
//                    [4] overrun [5] frame_err [6] parity_err [7] tx_busy
//                 W: bits 4..6 write-1-to-clear (a coinciding set wins)
//   ADDR_CTRL     [15:0] divisor (values below 4 stored as 4)
//
// Handshake: an access is cyc && stb && !ack; its side effect happens in that
// cycle and wb_ack_o (with registered wb_data_o) follows for exactly one cycle.
//
// Ports:
//   clk, resetn               clock, asynchronous active-low reset
//   wb_cyc_i .. wb_sel_i      Wishbone slave inputs (sel ignored)
//   wb_ack_o, wb_stall_o      acknowledge, stall (tied 0)
//   wb_data_o                 registered read data
//   irq_o                     level interrupt: rx data or any sticky error
//   tx_o, rx_i                serial line out (idle high) / in (asynchronous)
module wb_uart_fifo #(
    parameter int          CLK_FREQ     = 100_000_000,
    parameter int          BAUD_RATE    = 115200,
    parameter int          DATA_BITS    = 8,
    parameter int          STOP_BITS    = 1,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] ADDR_TX_DATA = 32'h0,
    parameter logic [31:0] ADDR_RX_DATA = 32'h4,
    parameter logic [31:0] ADDR_STATUS  = 32'h8,
    parameter logic [31:0] ADDR_CTRL    = 32'hC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_addr_i,
    input  logic [31:0] wb_data_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic        wb_stall_o,
    output logic [31:0] wb_data_o,
    output logic        irq_o,
    output logic        tx_o,
    input  logic        rx_i
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_RESET = 16'(CLK_FREQ / BAUD_RATE);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    // ---------------- bus decode ----------------
    logic access, wr_tx, wr_status, wr_ctrl, rd_rx;
    assign access    = wb_cyc_i && wb_stb_i && !wb_ack_o;
    assign wr_tx     = access && wb_we_i && (wb_addr_i == ADDR_TX_DATA);
    assign wr_status = access && wb_we_i && (wb_addr_i == ADDR_STATUS);
    assign wr_ctrl   = access && wb_we_i && (wb_addr_i == ADDR_CTRL);
    assign rd_rx     = access && !wb_we_i && (wb_addr_i == ADDR_RX_DATA);
    assign wb_stall_o = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, wb_sel_i, wb_data_i};

    logic [15:0] div;
    logic        overrun, frame_err, parity_err;
    logic        par_en, par_odd;

    // ---------------- FIFOs ----------------
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic tx_empty, tx_full, tx_push, tx_pop;
    logic rx_empty, rx_full, rx_push, rx_pop;
    logic [DATA_BITS-1:0] tx_head, rx_head;

    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = (tx_wptr[AW] != tx_rptr[AW]) && (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
    assign rx_empty = (rx_wptr == rx_rptr);
    assign rx_full  = (rx_wptr[AW] != rx_rptr[AW]) && (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);
    assign tx_head  = tx_mem[tx_rptr[AW-1:0]];
    assign rx_head  = rx_mem[rx_rptr[AW-1:0]];
    assign tx_push  = wr_tx && !tx_full;
    assign rx_pop   = rd_rx && !rx_empty;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= wb_data_i[DATA_BITS-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
        end
    end

    // ---------------- TX FSM ----------------
    state_t               tx_state;
    logic [15:0]          tx_cnt, tx_div;
    logic [DATA_BITS-1:0] tx_shift;
    logic [2:0]           tx_bit;
    logic                 tx_stop_idx;
    logic                 tx_tick, tx_busy;

    assign tx_tick = (tx_cnt == tx_div - 16'd1);
    assign tx_busy = (tx_state != S_IDLE);
    // A new frame is loaded from IDLE, or straight out of the last stop bit so
    // consecutive frames have no idle gap.
    assign tx_pop  = !tx_empty && ((tx_state == S_IDLE) ||
                     ((tx_state == S_STOP) && tx_tick && (tx_stop_idx == LAST_STOP)));

`ifdef WB_UART_PARITY_EN
    logic tx_par, tx_par_on;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state    <= S_IDLE;
            tx_cnt      <= '0;
            tx_div      <= DIV_RESET;
            tx_shift    <= '0;
            tx_bit      <= '0;
            tx_stop_idx <= 1'b0;
            tx_o        <= 1'b1;
`ifdef WB_UART_PARITY_EN
            tx_par      <= 1'b0;
            tx_par_on   <= 1'b0;
`endif
        end else begin
            tx_cnt <= tx_tick ? 16'd0 : tx_cnt + 16'd1;
            case (tx_state)
                S_IDLE: tx_cnt <= '0;
                S_START: if (tx_tick) begin
                    tx_o     <= tx_shift[0];
                    tx_bit   <= '0;
                    tx_state <= S_DATA;
                end
                S_DATA: if (tx_tick) begin
                    if (tx_bit == LAST_BIT) begin
`ifdef WB_UART_PARITY_EN
                        if (tx_par_on) begin
                            tx_o     <= tx_par;
                            tx_state <= S_PARITY;
                        end else
`endif
                        begin
                            tx_o        <= 1'b1;
                            tx_stop_idx <= 1'b0;
                            tx_state    <= S_STOP;
                        end
                    end else begin
                        tx_shift <= tx_shift >> 1;
                        tx_o     <= tx_shift[1];
                        tx_bit   <= tx_bit + 3'd1;
                    end
                end
`ifdef WB_UART_PARITY_EN
                S_PARITY: if (tx_tick) begin
                    tx_o        <= 1'b1;
                    tx_stop_idx <= 1'b0;
                    tx_state    <= S_STOP;
                end
`endif
                S_STOP: if (tx_tick) begin
                    if (tx_stop_idx == LAST_STOP) tx_state <= S_IDLE;
                    else tx_stop_idx <= 1'b1;
                end
                default: tx_state <= S_IDLE;
            endcase
            // Frame load overrides the case above (IDLE and end of STOP).
            if (tx_pop) begin
                tx_shift <= tx_head;
                tx_div   <= div;
                tx_cnt   <= '0;
                tx_o     <= 1'b0;
                tx_state <= S_START;
`ifdef WB_UART_PARITY_EN
                tx_par    <= (^tx_head) ^ par_odd;
                tx_par_on <= par_en;
`endif
            end
        end
    end

    // ---------------- RX FSM ----------------
    state_t               rx_state;
    logic [1:0]           rx_sync;
    logic                 rx_s, rx_prev;
    logic [15:0]          rx_cnt, rx_div;
    logic [DATA_BITS-1:0] rx_shift;
    logic [2:0]           rx_bit;
    logic                 rx_tick, rx_half, rx_stop_smp, rx_good;
    logic                 frame_set, overrun_set, parity_set, rx_par_bad;

    assign rx_s        = rx_sync[1];
    assign rx_tick     = (rx_cnt == rx_div - 16'd1);
    assign rx_half     = (rx_cnt == (rx_div >> 1) - 16'd1);
    assign rx_stop_smp = (rx_state == S_STOP) && rx_tick;
    assign frame_set   = rx_stop_smp && !rx_s;
    assign rx_good     = rx_stop_smp && rx_s && !rx_par_bad;
    assign overrun_set = rx_good && rx_full && !rx_pop;
    assign rx_push     = rx_good && !overrun_set;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= rx_shift;
    end

`ifdef WB_UART_PARITY_EN
    logic rx_par_on, rx_odd;
    assign parity_set = (rx_state == S_PARITY) && rx_tick && (rx_s != ((^rx_shift) ^ rx_odd));
`else
    assign parity_set = 1'b0;
    assign rx_par_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_div   <= DIV_RESET;
            rx_shift <= '0;
            rx_bit   <= '0;
`ifdef WB_UART_PARITY_EN
            rx_par_bad <= 1'b0;
            rx_par_on  <= 1'b0;
            rx_odd     <= 1'b0;
`endif
        end else begin
            rx_sync <= {rx_sync[0], rx_i};
            rx_prev <= rx_s;
            rx_cnt  <= rx_tick ? 16'd0 : rx_cnt + 16'd1;
            case (rx_state)
                S_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_s) begin
                        rx_div   <= div;
                        rx_state <= S_START;
`ifdef WB_UART_PARITY_EN
                        rx_par_bad <= 1'b0;
                        rx_par_on  <= par_en;
                        rx_odd     <= par_odd;
`endif
                    end
                end
                // Half a bit after the edge: still low means a real start bit,
                // and later samples land on bit centres.
                S_START: begin
                    rx_cnt <= rx_half ? 16'd0 : rx_cnt + 16'd1;
                    if (rx_half) begin
                        rx_bit   <= '0;
                        rx_state <= rx_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: if (rx_tick) begin
                    rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                    if (rx_bit == LAST_BIT) begin
`ifdef WB_UART_PARITY_EN
                        rx_state <= rx_par_on ? S_PARITY : S_STOP;
`else
                        rx_state <= S_STOP;
`endif
                    end else begin
                        rx_bit <= rx_bit + 3'd1;
                    end
                end
`ifdef WB_UART_PARITY_EN
                S_PARITY: if (rx_tick) begin
                    rx_par_bad <= parity_set;
                    rx_state   <= S_STOP;
                end
`endif
                S_STOP: if (rx_tick) rx_state <= rx_s ? S_IDLE : S_WAIT_HIGH;
                S_WAIT_HIGH: if (rx_s) rx_state <= S_IDLE;
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- registers, flags, bus response ----------------
    logic [31:0] rd_data, status;
    assign status = {24'd0, tx_busy, parity_err, frame_err, overrun,
                     rx_full, !rx_empty, tx_full, tx_empty};

    always_comb begin
        rd_data = '0;
        if (wb_addr_i == ADDR_RX_DATA && !rx_empty) rd_data = 32'(rx_head);
        else if (wb_addr_i == ADDR_STATUS)          rd_data = status;
        else if (wb_addr_i == ADDR_CTRL)            rd_data = {14'd0, par_odd, par_en, div};
    end

`ifndef WB_UART_PARITY_EN
    assign par_en     = 1'b0;
    assign par_odd    = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_ack_o   <= 1'b0;
            wb_data_o  <= '0;
            irq_o      <= 1'b0;
            div        <= DIV_RESET;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
`ifdef WB_UART_PARITY_EN
            parity_err <= 1'b0;
            par_en     <= 1'b0;
            par_odd    <= 1'b0;
`endif
        end else begin
            wb_ack_o <= access;
            if (access) wb_data_o <= wb_we_i ? 32'd0 : rd_data;
            if (wr_ctrl) begin
                div <= (wb_data_i[15:0] < 16'd4) ? 16'd4 : wb_data_i[15:0];
`ifdef WB_UART_PARITY_EN
                par_en  <= wb_data_i[16];
                par_odd <= wb_data_i[17];
`endif
            end
            overrun   <= overrun_set | (overrun & !(wr_status && wb_data_i[4]));
            frame_err <= frame_set | (frame_err & !(wr_status && wb_data_i[5]));
`ifdef WB_UART_PARITY_EN
            parity_err <= parity_set | (parity_err & !(wr_status && wb_data_i[6]));
`endif
            irq_o <= !rx_empty | overrun | frame_err | parity_err;
        end
    end
endmodule

// File: tb/tb_wb_uart_fifo.sv
// Directed testbench for wb_uart_fifo at div=10, 8 data bits, 4-entry FIFOs.
module tb_wb_uart_fifo;
    localparam logic [31:0] A_TX   = 32'h0;
    localparam logic [31:0] A_RX   = 32'h4;
    localparam logic [31:0] A_STAT = 32'h8;
    localparam logic [31:0] A_CTRL = 32'hC;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0] wb_addr_i, wb_data_i;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o, wb_stall_o;
    logic [31:0] wb_data_o;
    logic        irq_o, tx_o, rx_i;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    wb_uart_fifo #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
        .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .resetn(resetn),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_sel_i(wb_sel_i),
        .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o), .wb_data_o(wb_data_o),
        .irq_o(irq_o), .tx_o(tx_o), .rx_i(rx_i)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           output logic [31:0] rdata);
        int n;
        @(posedge clk);
        #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_addr_i = addr; wb_data_i = data;
        n = 0;
        while (!wb_ack_o && n < 20) begin
            tick();
            n++;
        end
        rdata = wb_data_o;
        if (!wb_ack_o) check("wb_ack_timeout", {31'd0, wb_ack_o}, 32'd1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        wb_xfer(1'b1, addr, data, dummy);
    endtask

    task automatic wb_read(input logic [31:0] addr, output logic [31:0] data);
        wb_xfer(1'b0, addr, 32'd0, data);
    endtask

    // Drives one frame on rx_i, 10 cycles per bit, LSB first.
    task automatic rx_send(input logic [7:0] b, input logic par_on, input logic par_bit,
                           input logic stop_val);
        rx_i = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (10) tick();
        end
        if (par_on) begin
            rx_i = par_bit;
            repeat (10) tick();
        end
        rx_i = stop_val;
        repeat (10) tick();
        rx_i = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rd;
    logic [99:0] wave;
    logic [9:0]  exp_bits;

    initial begin
        resetn = 1'b0; rx_i = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_addr_i = '0; wb_data_i = '0; wb_sel_i = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_o", {31'd0, tx_o}, 32'd1);
        check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        check("rst_rdata", wb_data_o, 32'd0);
        resetn = 1'b1;
        wb_read(A_STAT, rd); check("rst_status", rd, 32'h01);
        wb_read(A_CTRL, rd); check("rst_ctrl", rd, 32'd10);

        // 1: single byte 0xA5, bit-exact waveform
        fork
            begin
                wb_write(A_TX, 32'hA5);
                wb_read(A_STAT, rd);
                check("t1_status_busy", rd, 32'h81);
            end
            begin : t1_mon
                int n;
                n = 0;
                while (tx_o && n < 50) begin tick(); n++; end
                for (int s = 0; s < 100; s++) begin
                    wave[s] = tx_o;
                    tick();
                end
            end
        join
        exp_bits = {1'b1, 8'hA5, 1'b0};
        for (int b = 0; b < 10; b++)
            check("t1_tx_bit", {22'd0, wave[b*10 +: 10]}, {22'd0, {10{exp_bits[b]}}});
        wb_read(A_STAT, rd); check("t1_status_idle", rd, 32'h01);

        // 2: six writes, 0x01 popped at once, 0x02..0x05 fill the FIFO, 0x06 dropped
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        fork
            begin
                for (int i = 1; i <= 6; i++) wb_write(A_TX, 32'(i));
                wb_read(A_STAT, rd);
                check("t2_tx_full", rd, 32'h82);
            end
            begin : t2_dec
                int n;
                logic [7:0] d;
                logic st, sp;
                for (int f = 0; f < 5; f++) begin
                    n = 0;
                    while (tx_o && n < 300) begin tick(); n++; end
                    if (f > 0) check("t2_gap", 32'(n), 32'd5);
                    repeat (5) tick();
                    st = tx_o;
                    for (int b = 0; b < 8; b++) begin
                        repeat (10) tick();
                        d[b] = tx_o;
                    end
                    repeat (10) tick();
                    sp = tx_o;
                    check("t2_frame_bits", {30'd0, sp, st}, 32'h2);
                    check("t2_data", {24'd0, d}, {24'd0, exp_q.pop_front()});
                end
                n = 0;
                while (tx_o && n < 150) begin tick(); n++; end
                check("t2_no_extra", 32'(n), 32'd150);
            end
        join

        // 3: receive 0x3C, irq follows FIFO occupancy
        rx_send(8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (2) tick();
        check("t3_irq_set", {31'd0, irq_o}, 32'd1);
        wb_read(A_STAT, rd); check("t3_status", rd, 32'h05);
        wb_read(A_RX, rd); check("t3_rx_data", rd, 32'h3C);
        repeat (2) tick();
        check("t3_irq_clr", {31'd0, irq_o}, 32'd0);
        wb_read(A_RX, rd); check("t3_rx_empty_read", rd, 32'h0);

        // 4: five frames into a 4-entry FIFO -> overrun, order preserved
        for (int i = 1; i <= 5; i++) begin
            rx_send(8'(i * 8'h11), 1'b0, 1'b0, 1'b1);
            if (i <= 4) exp_q.push_back(8'(i * 8'h11));
        end
        repeat (2) tick();
        wb_read(A_STAT, rd); check("t4_status_ovr", rd, 32'h1D);
        wb_write(A_STAT, 32'h10);
        wb_read(A_STAT, rd); check("t4_status_clr", rd, 32'h0D);
        for (int i = 0; i < 4; i++) begin
            wb_read(A_RX, rd);
            check("t4_rx_order", rd, {24'd0, exp_q.pop_front()});
        end
        wb_read(A_STAT, rd); check("t4_status_empty", rd, 32'h01);

        // 5: framing error, glitch rejection, divisor clamp, unmapped access
        rx_send(8'h5A, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        check("t5_irq_ferr", {31'd0, irq_o}, 32'd1);
        wb_read(A_STAT, rd); check("t5_status_ferr", rd, 32'h21);
        wb_write(A_STAT, 32'h20);
        wb_read(A_STAT, rd); check("t5_ferr_clr", rd, 32'h01);
        rx_i = 1'b0;
        repeat (3) tick();
        rx_i = 1'b1;
        repeat (120) tick();
        wb_read(A_STAT, rd); check("t5_glitch", rd, 32'h01);
        wb_write(A_CTRL, 32'd2);
        wb_read(A_CTRL, rd); check("t5_ctrl_clamp", rd, 32'd4);
        wb_write(A_CTRL, 32'd10);
        wb_write(32'h10, 32'h1234);
        wb_read(A_CTRL, rd); check("t5_unmapped_wr", rd, 32'd10);
        wb_read(32'h10, rd); check("t5_unmapped_rd", rd, 32'd0);
        wb_read(A_TX, rd); check("t5_txdata_rd", rd, 32'd0);

`ifdef WB_UART_PARITY_EN
        // 6: odd parity, 0x07 has three ones so the correct parity bit is 0
        wb_write(A_CTRL, 32'h3000A);
        wb_read(A_CTRL, rd); check("t6_ctrl", rd, 32'h3000A);
        rx_send(8'h07, 1'b1, 1'b1, 1'b1);
        repeat (2) tick();
        wb_read(A_STAT, rd); check("t6_par_err", rd, 32'h41);
        wb_write(A_STAT, 32'h40);
        rx_send(8'h07, 1'b1, 1'b0, 1'b1);
        repeat (2) tick();
        wb_read(A_STAT, rd); check("t6_par_ok_status", rd, 32'h05);
        wb_read(A_RX, rd); check("t6_par_ok_data", rd, 32'h07);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
